// File: rtl/b06_pkg.sv
// Shared definitions for the b06 interrupt-handler slice: compare-select codes
// and the counter state encoding.
package b06_pkg;

  // Compare-select codes driven by the b06 FSM on CC_MUX.
  typedef enum logic [1:0] {
    cc_nop   = 2'b00,
    cc_enin  = 2'b01,
    cc_intr  = 2'b10,
    cc_ackin = 2'b11
  } cc_mux_t;

  // Terminal-count counter states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_t;

endpackage

// File: rtl/b06_count_cmp_if.sv
// Signal bundle between the b06 FSM (master) and the count/compare block (slave).
interface b06_count_cmp_if #(
  parameter int REQ_W = 4,
  parameter int CNT_W = 4
);

  logic [REQ_W-1:0] REQ;
  logic [REQ_W-1:0] REF_ENIN;
  logic [REQ_W-1:0] REF_INTR;
  logic [REQ_W-1:0] REF_ACKIN;
  logic [1:0]       CC_MUX;
  logic             ENABLE_COUNT;
  logic             ACKOUT;
  logic             EQL;
  logic             CONT_EQL;
  logic [CNT_W-1:0] COUNT;
  logic             ERR;

  modport master (
    output REQ, REF_ENIN, REF_INTR, REF_ACKIN, CC_MUX, ENABLE_COUNT, ACKOUT,
    input  EQL, CONT_EQL, COUNT, ERR
  );

  modport slave (
    input  REQ, REF_ENIN, REF_INTR, REF_ACKIN, CC_MUX, ENABLE_COUNT, ACKOUT,
    output EQL, CONT_EQL, COUNT, ERR
  );

endinterface

// File: rtl/b06_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module b06_sync2 #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  // Two register stages to resolve metastability on the asynchronous input.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/b06_count_cmp.sv
// Upstream companion of the b06 interrupt-handler FSM: produces EQL (synchronised
// request vs selected reference code) and CONT_EQL (gated counter at terminal
// count), and flags ENABLE_COUNT/ACKOUT disagreement on a sticky ERR.
module b06_count_cmp
  import b06_pkg::*;
#(
  parameter int REQ_W = 4,
  parameter int CNT_W = 4,
  parameter int TERM  = 9
) (
  input logic            clock,
  input logic            reset,
  b06_count_cmp_if.slave bus
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  if (TERM < 1 || TERM > (2**CNT_W) - 1) begin : g_bad_term
    $error("b06_count_cmp: TERM must lie in 1..2**CNT_W-1");
  end

  logic [REQ_W-1:0] req_s2;
  logic [REQ_W-1:0] ref_sel;
  logic             ref_valid;
  logic             eql;

  cnt_state_t       state;
  cnt_state_t       state_nx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] count_inc;
  logic             cont_eql;
  logic             err;

  b06_sync2 #(.W(REQ_W)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.REQ),
    .q     (req_s2)
  );

  // Reference code selected by the FSM's compare-select.
  always_comb begin
    ref_sel   = '0;
    ref_valid = 1'b0;
    case (cc_mux_t'(bus.CC_MUX))
      cc_enin:  begin ref_sel = bus.REF_ENIN;  ref_valid = 1'b1; end
      cc_intr:  begin ref_sel = bus.REF_INTR;  ref_valid = 1'b1; end
      cc_ackin: begin ref_sel = bus.REF_ACKIN; ref_valid = 1'b1; end
      default:  begin ref_sel = '0;            ref_valid = 1'b0; end
    endcase
  end

  // Registered compare of the synchronised request against the selected code.
  always_ff @(posedge clock) begin
    if (reset) eql <= 1'b0;
    else       eql <= ref_valid && (req_s2 == ref_sel);
  end

  assign count_inc = count + ONE_C;

  // Counter next-state and next-count; counts only while ENABLE_COUNT is high
  // and holds at TERM until ACKOUT clears it.
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      IDLE: begin
        count_nx = '0;
        if (bus.ENABLE_COUNT) begin
          count_nx = ONE_C;
          state_nx = (TERM_C == ONE_C) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.ENABLE_COUNT) begin
          count_nx = count_inc;
          if (count_inc == TERM_C) state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.ACKOUT) begin
          count_nx = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        count_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Counter state, count and terminal-count flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      cont_eql <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      cont_eql <= (state_nx == DONE);
    end
  end

  // Sticky protocol-violation flag: the FSM must keep ENABLE_COUNT == ACKOUT.
  always_ff @(posedge clock) begin
    if (reset) err <= 1'b0;
    else       err <= err | (bus.ENABLE_COUNT != bus.ACKOUT);
  end

  assign bus.EQL      = eql;
  assign bus.CONT_EQL = cont_eql;
  assign bus.COUNT    = count;
  assign bus.ERR      = err;

  a_count_le_term : assert property (@(posedge clock) disable iff (reset)
    count <= TERM_C);
  a_cont_at_term : assert property (@(posedge clock) disable iff (reset)
    cont_eql |-> (count == TERM_C));
  a_nop_clears_eql : assert property (@(posedge clock) disable iff (reset)
    (bus.CC_MUX == cc_nop) |=> !eql);

endmodule

// File: tb/tb_b06_count_cmp.sv
// Randomised plus directed bench for b06_count_cmp; a TERM=9 and a TERM=1 build
// share the same stimulus and are checked against a behavioural model.
module tb_b06_count_cmp;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req, r_enin, r_intr, r_ackin;
  logic [1:0] cc;
  logic       en, ack;

  int total = 0;
  int bad   = 0;

  // Model state
  int         m_cnt  [2];
  bit         m_fin  [2];
  int         m_term [2] = '{9, 1};
  bit         m_err;
  bit         m_eql;
  logic [3:0] m_hist [$];

  always #5 clock = ~clock;

  b06_count_cmp_if #(.REQ_W(4), .CNT_W(4)) bus9 ();
  b06_count_cmp_if #(.REQ_W(4), .CNT_W(4)) bus1 ();

  assign bus9.REQ = req;   assign bus9.REF_ENIN = r_enin; assign bus9.REF_INTR = r_intr;
  assign bus9.REF_ACKIN = r_ackin; assign bus9.CC_MUX = cc;
  assign bus9.ENABLE_COUNT = en;   assign bus9.ACKOUT = ack;
  assign bus1.REQ = req;   assign bus1.REF_ENIN = r_enin; assign bus1.REF_INTR = r_intr;
  assign bus1.REF_ACKIN = r_ackin; assign bus1.CC_MUX = cc;
  assign bus1.ENABLE_COUNT = en;   assign bus1.ACKOUT = ack;

  b06_count_cmp #(.REQ_W(4), .CNT_W(4), .TERM(9)) u_dut9 (
    .clock (clock), .reset (reset), .bus (bus9.slave));
  b06_count_cmp #(.REQ_W(4), .CNT_W(4), .TERM(1)) u_dut1 (
    .clock (clock), .reset (reset), .bus (bus1.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs held across that edge.
  task automatic model_step();
    logic [3:0] ref_code;
    if (reset) begin
      m_eql = 1'b0;
      m_err = 1'b0;
      m_hist = '{4'h0, 4'h0};
      for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_fin[d] = 1'b0; end
      return;
    end
    ref_code = (cc == 2'd1) ? r_enin : (cc == 2'd2) ? r_intr : r_ackin;
    // EQL reflects the request sampled two edges earlier.
    m_eql = (cc != 2'd0) && (m_hist[0] == ref_code);
    void'(m_hist.pop_front());
    m_hist.push_back(req);
    if (en != ack) m_err = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (m_fin[d]) begin
        if (ack) begin m_cnt[d] = 0; m_fin[d] = 1'b0; end
      end else if (en) begin
        m_cnt[d] = m_cnt[d] + 1;
        m_fin[d] = (m_cnt[d] == m_term[d]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
    check_eq("eql9",  32'(bus9.EQL),      32'(m_eql));
    check_eq("cont9", 32'(bus9.CONT_EQL), 32'(m_fin[0]));
    check_eq("cnt9",  32'(bus9.COUNT),    32'(m_cnt[0]));
    check_eq("err9",  32'(bus9.ERR),      32'(m_err));
    check_eq("eql1",  32'(bus1.EQL),      32'(m_eql));
    check_eq("cont1", 32'(bus1.CONT_EQL), 32'(m_fin[1]));
    check_eq("cnt1",  32'(bus1.COUNT),    32'(m_cnt[1]));
    check_eq("err1",  32'(bus1.ERR),      32'(m_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ctl(input logic e, input logic a);
    en = e; ack = a;
  endtask

  initial begin
    reset = 1'b1; req = 4'hF; en = 1'b1; ack = 1'b1; cc = 2'b00;
    r_enin = 4'h1; r_intr = 4'h2; r_ackin = 4'h5;
    m_hist = '{4'h0, 4'h0};

    // Reset held 2 cycles with activity on the inputs.
    ticks(2);
    check_eq("rst_cnt", 32'(bus9.COUNT), 32'd0);
    check_eq("rst_err", 32'(bus9.ERR), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("first_cnt", 32'(bus9.COUNT), 32'd1);
    check_eq("term1_done", 32'(bus1.CONT_EQL), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;

    // Compare latency: REQ change to EQL is 3 clocks; CC_MUX=00 clears in 1.
    set_ctl(0, 0); req = 4'h0; cc = 2'b11; r_ackin = 4'h5;
    ticks(3);
    req = 4'h5;
    ticks(2);
    check_eql_low: check_eq("lat_2clk", 32'(bus9.EQL), 32'd0);
    tick();
    check_eq("lat_3clk", 32'(bus9.EQL), 32'd1);
    cc = 2'b00; tick();
    check_eq("nop_eql", 32'(bus9.EQL), 32'd0);

    // Full count to TERM, hold, then acknowledge.
    set_ctl(1, 1); ticks(9);
    check_eq("full_cnt", 32'(bus9.COUNT), 32'd9);
    check_eq("full_cont", 32'(bus9.CONT_EQL), 32'd1);
    set_ctl(0, 0); ticks(3);
    check_eq("hold_cnt", 32'(bus9.COUNT), 32'd9);
    set_ctl(1, 1); tick();
    check_eq("ack_cnt", 32'(bus9.COUNT), 32'd0);

    // Pause at 3, resume to 4.
    ticks(3);
    set_ctl(0, 0); ticks(4);
    check_eq("pause_cnt", 32'(bus9.COUNT), 32'd3);
    set_ctl(1, 1); tick();
    check_eq("resume_cnt", 32'(bus9.COUNT), 32'd4);

    // Reset mid-count at 6.
    ticks(2);
    check_eq("pre_rst_cnt", 32'(bus9.COUNT), 32'd6);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("mid_rst_cnt", 32'(bus9.COUNT), 32'd0);

    // Protocol error is sticky until reset.
    set_ctl(1, 0); tick();
    set_ctl(1, 1); ticks(3);
    check_eq("err_sticky", 32'(bus9.ERR), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("err_clear", 32'(bus9.ERR), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      req = 4'($urandom_range(0, 3));
      cc = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        r_enin = 4'($urandom_range(0, 3));
        r_intr = 4'($urandom_range(0, 3));
        r_ackin = 4'($urandom_range(0, 3));
      end
      en = 1'($urandom);
      ack = ($urandom_range(0, 29) == 0) ? ~en : en;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
